dct_zigzag_serializer: RTL and testbench
========================================

# dct_zigzag_serializer

Consumer-side companion to the DCT transpose line buffer. It accepts one 8-coefficient column of a DCT block per beat and stores the complete 8x8 block in a ping-pong buffer. It then emits the 64 coefficients one per cycle, in JPEG zigzag order, to the quantizer/entropy stage under a valid/ready handshake. Two banks let the next block load while the current one drains.

## Interface
- DATA_W, 12, signed coefficient width (input and output)
- i_clk  input  1  clock, all state on rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_valid  input  1  column beat present on i_data0..7
- i_data0..i_data7  input  DATA_W each  coefficient rows 0..7 of current column
- o_ready  output  1  serializer can accept a column beat this cycle
- o_valid  output  1  o_data holds a valid coefficient
- o_data  output  DATA_W  serialized coefficient
- o_last  output  1  high with the 64th coefficient of a block
- i_ready  input  1  downstream accepts o_data this cycle

## Operation
- Storage: 2 banks x 64 x DATA_W. Element (r,c) = row r, column c.
- Write side:
  - wr_bank (1 bit) selects the bank; wr_col (3 bits) counts columns.
  - Beat accepted when i_valid && o_ready: bank[wr_bank][r][wr_col] <= i_data{r} for r = 0..7.
  - Accepted beat with wr_col==7: full[wr_bank] <= 1, wr_bank toggles, wr_col wraps to 0. Otherwise wr_col increments.
  - o_ready = !full[wr_bank]. i_valid while o_ready==0 is ignored; nothing is stored and no counter moves.
- Read side:
  - rd_bank (1 bit) selects the bank; rd_idx (6 bits) is the scan position.
  - o_valid = full[rd_bank].
  - o_data = bank[rd_bank][scan(rd_idx)] when o_valid, else 0.
  - o_last = o_valid && rd_idx==63.
  - Transfer occurs when o_valid && i_ready: rd_idx increments. On the transfer with rd_idx==63: full[rd_bank] <= 0, rd_bank toggles, rd_idx wraps to 0.
- scan(k): the standard JPEG zigzag table mapping k to raster index r*8+c. Sequence: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
- Data passes through unmodified. No arithmetic and no sign change.
- Simultaneous events:
  - Set of full on one bank and clear on the other in the same cycle are both applied.
  - wr_bank==rd_bank cannot produce a conflict: that bank is either full (no write accepted) or empty (no read valid).

## Timing
- Reset (async assert) values: wr_bank=0, wr_col=0, rd_bank=0, rd_idx=0, full=2'b00. Outputs: o_ready=1, o_valid=0, o_last=0, o_data=0. Storage contents are not reset.
- Latency: o_valid rises in the cycle after the 8th column beat is accepted, and first o_data is valid in that cycle.
- Throughput with i_ready=1: 64 output cycles per block.
- Input accepts at most 16 consecutive beats (two banks) before o_ready falls. o_ready returns high the cycle after the draining bank's o_last transfer.
- While o_valid && !i_ready, o_data and o_last stay stable.
- Reset asserted mid-block discards both banks' status immediately. After release, the next accepted column starts a new block in bank 0.

## Configuration
- DCT_ZIGZAG_EN defined: scan(k) is the zigzag table above.
- DCT_ZIGZAG_EN undefined: scan(k)=k, giving row-major raster order (r = k[5:3], c = k[2:0]). All handshake and timing behaviour is identical in both builds.

## Test plan
- Zigzag build, load one block with element (r,c)=r*8+c, i_ready=1 -> o_valid high for 64 consecutive cycles starting the cycle after beat 8; o_data = 0,1,8,16,9,2,3,10,...,62,63; o_last only on the 64th cycle.
- Raster build, same stimulus -> o_data = 0,1,2,...,63, with o_last on 63.
- i_valid held high for 3 blocks, i_ready=1 -> o_ready low after 16 beats and high again the cycle after the first o_last transfer. Three blocks are emitted in order with no lost or duplicated values.
- i_ready toggling 1,0,1,0 -> exactly 64 transfers per block; o_data and o_last unchanged during every stalled cycle.
- Assert i_rst_n low after 30 output transfers -> o_valid, o_last and o_data go to 0 and o_ready goes to 1 without waiting for a clock edge. After release, a new block is emitted starting from scan index 0.
- Coefficients -2048 and 2047 placed at (0,0) and (7,7) -> output as the first and last coefficient with bit patterns unchanged.

Source files
------------

// File: rtl/dct_zigzag_serializer.sv
// Ping-pong 8x8 coefficient buffer: column beats in, one coefficient per cycle out.
// Define DCT_ZIGZAG_EN for JPEG zigzag read order; otherwise blocks drain in raster order.
module dct_zigzag_serializer #(
    parameter int DATA_W = 12
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    input  logic signed [DATA_W-1:0] i_data0,
    input  logic signed [DATA_W-1:0] i_data1,
    input  logic signed [DATA_W-1:0] i_data2,
    input  logic signed [DATA_W-1:0] i_data3,
    input  logic signed [DATA_W-1:0] i_data4,
    input  logic signed [DATA_W-1:0] i_data5,
    input  logic signed [DATA_W-1:0] i_data6,
    input  logic signed [DATA_W-1:0] i_data7,
    output logic                     o_ready,
    output logic                     o_valid,
    output logic signed [DATA_W-1:0] o_data,
    output logic                     o_last,
    input  logic                     i_ready
);
    localparam int ROWS  = 8;
    localparam int CELLS = 64;

`ifdef DCT_ZIGZAG_EN
    localparam logic [5:0] SCAN [CELLS] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };
`endif

    logic signed [DATA_W-1:0]     mem [2][CELLS];
    logic [ROWS-1:0][DATA_W-1:0]  col;
    logic                         wr_bank, rd_bank;
    logic [2:0]                   wr_col;
    logic [5:0]                   rd_idx, rd_addr;
    logic [1:0]                   full, full_nxt;
    logic                         wr_fire, rd_fire, wr_done, rd_done;

    assign col = {i_data7, i_data6, i_data5, i_data4, i_data3, i_data2, i_data1, i_data0};

    // A bank is never written and read at once: full blocks writes, empty blocks reads.
    assign o_ready = !full[wr_bank];
    assign o_valid = full[rd_bank];
    assign wr_fire = i_valid && o_ready;
    assign rd_fire = o_valid && i_ready;
    assign wr_done = wr_fire && (wr_col == 3'd7);
    assign rd_done = rd_fire && (rd_idx == 6'd63);

`ifdef DCT_ZIGZAG_EN
    assign rd_addr = SCAN[rd_idx];
`else
    assign rd_addr = rd_idx;
`endif

    assign o_data = o_valid ? mem[rd_bank][rd_addr] : '0;
    assign o_last = o_valid && (rd_idx == 6'd63);

    // Storage holds data only; status lives in full[], so no reset here.
    always_ff @(posedge i_clk) begin
        if (wr_fire) begin
            for (int r = 0; r < ROWS; r++) begin
                mem[wr_bank][{r[2:0], wr_col}] <= col[r];
            end
        end
    end

    always_comb begin
        full_nxt = full;
        if (wr_done) full_nxt[wr_bank] = 1'b1;
        if (rd_done) full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_bank <= 1'b0;
            wr_col  <= '0;
            rd_bank <= 1'b0;
            rd_idx  <= '0;
            full    <= '0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                wr_col <= wr_col + 3'd1;
                if (wr_done) wr_bank <= ~wr_bank;
            end
            if (rd_fire) begin
                rd_idx <= rd_idx + 6'd1;
                if (rd_done) rd_bank <= ~rd_bank;
            end
        end
    end
endmodule

// File: tb/tb_dct_zigzag_serializer.sv
// Directed bench for dct_zigzag_serializer; expected scan order follows DCT_ZIGZAG_EN.
module tb_dct_zigzag_serializer;
    logic              i_clk, i_rst_n, i_valid, i_ready;
    logic signed [11:0] din [8];
    logic              o_ready, o_valid, o_last;
    logic [11:0]       dout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rdy;
        logic        vld;
        logic [11:0] data;
        logic        last;
        logic        ordy;
    } vec_t;

    vec_t        tbl [$];
    logic [11:0] blk [64];

`ifdef DCT_ZIGZAG_EN
    int zz_tab [64] = '{
        0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };
    function automatic int zz(input int k);
        return zz_tab[k];
    endfunction
`else
    function automatic int zz(input int k);
        return k;
    endfunction
`endif

    dct_zigzag_serializer #(.DATA_W(12)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid),
        .i_data0(din[0]), .i_data1(din[1]), .i_data2(din[2]), .i_data3(din[3]),
        .i_data4(din[4]), .i_data5(din[5]), .i_data6(din[6]), .i_data7(din[7]),
        .o_ready(o_ready), .o_valid(o_valid), .o_data(dout), .o_last(o_last),
        .i_ready(i_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required to finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fill_blk(input int base);
        for (int i = 0; i < 64; i++) blk[i] = 12'(base + i);
    endtask

    task automatic load_block();
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            i_valid = 1'b1;
            i_ready = 1'b1;
            for (int r = 0; r < 8; r++) din[r] = blk[r*8 + c];
            #1;
            chk("load_ready", 32'(o_ready), 32'd1);
            chk("load_valid", 32'(o_valid), 32'd0);
        end
    endtask

    task automatic build_drain(input bit stall);
        tbl.delete();
        for (int k = 0; k < 64; k++) begin
            if (stall) tbl.push_back('{1'b0, 1'b1, blk[zz(k)], k == 63, 1'b1});
            tbl.push_back('{1'b1, 1'b1, blk[zz(k)], k == 63, 1'b1});
        end
        tbl.push_back('{1'b1, 1'b0, 12'd0, 1'b0, 1'b1});
    endtask

    task automatic apply_table(input string tag);
        foreach (tbl[i]) begin
            @(negedge i_clk);
            i_valid = 1'b0;
            i_ready = tbl[i].rdy;
            #1;
            chk({tag, "_valid"}, 32'(o_valid), 32'(tbl[i].vld));
            chk({tag, "_data"},  32'(dout),    32'(tbl[i].data));
            chk({tag, "_last"},  32'(o_last),  32'(tbl[i].last));
            chk({tag, "_ready"}, 32'(o_ready), 32'(tbl[i].ordy));
        end
    endtask

    initial begin
        int accepted, nout, b, k;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        for (int r = 0; r < 8; r++) din[r] = '0;
        #1;
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_last",  32'(o_last),  32'd0);
        chk("rst_data",  32'(dout),    32'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;

        // Block with (r,c)=r*8+c, continuous drain; first vector checks one-cycle latency.
        fill_blk(0);
        load_block();
        build_drain(1'b0);
        apply_table("scan");

        // Stalled drain: each coefficient held through a ready=0 cycle.
        fill_blk(100);
        load_block();
        build_drain(1'b1);
        apply_table("stall");

        // Extreme values at (0,0) and (7,7).
        for (int i = 0; i < 64; i++) blk[i] = '0;
        blk[0]  = 12'h800;
        blk[63] = 12'h7FF;
        load_block();
        build_drain(1'b0);
        apply_table("extreme");

        // Three blocks back to back, i_valid held high, i_ready=1.
        accepted = 0;
        nout     = 0;
        for (int cyc = 0; cyc < 220; cyc++) begin
            @(negedge i_clk);
            i_ready = 1'b1;
            i_valid = (accepted < 24);
            for (int r = 0; r < 8; r++) din[r] = 12'((accepted / 8) * 64 + r * 8 + accepted % 8);
            #1;
            if (cyc < 80) chk("stream_ready", 32'(o_ready), 32'(cyc < 16 || cyc >= 72));
            chk("stream_valid", 32'(o_valid), 32'(cyc >= 8 && cyc < 200));
            if (o_valid) begin
                b = nout / 64;
                k = nout % 64;
                chk("stream_data", 32'(dout),   32'(b * 64 + zz(k)));
                chk("stream_last", 32'(o_last), 32'(k == 63));
                nout++;
            end
            if (i_valid && o_ready) accepted++;
        end
        chk("stream_count", 32'(nout), 32'd192);
        chk("stream_beats", 32'(accepted), 32'd24);

        // Reset after 30 transfers while the other bank is partly loaded.
        fill_blk(300);
        load_block();
        for (int n = 0; n < 30; n++) begin
            @(negedge i_clk);
            i_ready = 1'b1;
            i_valid = (n < 3);
            for (int r = 0; r < 8; r++) din[r] = 12'(1000 + r);
            #1;
            chk("prerst_data", 32'(dout), 32'(blk[zz(n)]));
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        chk("prerst_valid", 32'(o_valid), 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_last",  32'(o_last),  32'd0);
        chk("midrst_data",  32'(dout),    32'd0);
        chk("midrst_ready", 32'(o_ready), 32'd1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        fill_blk(500);
        load_block();
        build_drain(1'b0);
        apply_table("postrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
